// File: rtl/rv32imf_prefetch_controller.sv
// Fetch request controller in front of the prefetch FIFO: issues word-aligned requests bounded by free
// FIFO space, drops stale responses after a redirect. Optional macro: RV32IMF_PREFETCH_BYPASS_EN.
module rv32imf_prefetch_controller #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic             branch_i,
    input  logic [31:0]      branch_addr_i,
    output logic             busy_o,
    output logic             trans_valid_o,
    input  logic             trans_ready_i,
    output logic [31:0]      trans_addr_o,
    input  logic             resp_valid_i,
    input  logic [31:0]      resp_rdata_i,
    output logic             fetch_valid_o,
    input  logic             fetch_ready_i,
    output logic [31:0]      fetch_rdata_o,
    output logic             fifo_flush_o,
    output logic             fifo_push_o,
    output logic             fifo_pop_o,
    input  logic [CNT_W-1:0] fifo_cnt_i,
    input  logic             fifo_empty_i,
    input  logic [31:0]      fifo_rdata_i
);

    localparam logic [0:0] IDLE        = 1'b0;
    localparam logic [0:0] BRANCH_WAIT = 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [0:0]       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W:0]   occupancy;
    logic [31:0]      branch_target;
    logic             credit;
    logic             accept;
    logic             resp_cnt;
    logic             drop;
    logic             bypass;

    assign branch_target = {branch_addr_i[31:2], 2'b00};
    assign occupancy     = {1'b0, fifo_cnt_i} + {1'b0, cnt_q};
    assign credit        = occupancy < (CNT_W + 1)'(DEPTH);
    // A response with nothing outstanding is ignored by the counters.
    assign resp_cnt      = resp_valid_i && (cnt_q != '0);
    assign drop          = (flush_cnt_q != '0) || branch_i;

`ifdef RV32IMF_PREFETCH_BYPASS_EN
    assign bypass = resp_valid_i && !drop && fifo_empty_i && fetch_ready_i;
`else
    assign bypass = 1'b0;
`endif

    // In BRANCH_WAIT addr_q holds target-4, so the sequential expression yields the pending target.
    always_comb begin
        trans_valid_o = 1'b0;
        trans_addr_o  = {addr_q[31:2], 2'b00} + 32'd4;
        if (branch_i) begin
            trans_valid_o = 1'b1;
            trans_addr_o  = branch_target;
        end else if (state_q == BRANCH_WAIT) begin
            trans_valid_o = 1'b1;
        end else begin
            trans_valid_o = req_i && credit;
        end
    end

    assign accept = trans_valid_o && trans_ready_i;

    always_comb begin
        state_d = state_q;
        if (branch_i || (state_q == BRANCH_WAIT)) begin
            state_d = trans_ready_i ? IDLE : BRANCH_WAIT;
        end

        addr_d = addr_q;
        if (accept) begin
            addr_d = trans_addr_o;
        end else if (branch_i) begin
            addr_d = branch_target - 32'd4;
        end

        cnt_d = cnt_q;
        if (accept && !resp_cnt) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!accept && resp_cnt) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        flush_cnt_d = flush_cnt_q;
        if (branch_i) begin
            flush_cnt_d = cnt_q - (resp_cnt ? CNT_ONE : '0);
        end else if (resp_valid_i && (flush_cnt_q != '0)) begin
            flush_cnt_d = flush_cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= 32'hFFFF_FFFC;
            cnt_q       <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fifo_flush_o  = branch_i;
    assign fifo_push_o   = resp_valid_i && !drop && !bypass;
    assign fifo_pop_o    = fetch_ready_i && !fifo_empty_i && !branch_i;
    assign fetch_valid_o = (!fifo_empty_i || bypass) && !branch_i;
    assign fetch_rdata_o = bypass ? resp_rdata_i : fifo_rdata_i;
    assign busy_o        = (cnt_q != '0) || trans_valid_o;

endmodule

// File: tb/tb_rv32imf_prefetch_controller.sv
// Bench for rv32imf_prefetch_controller: queue-based FIFO/memory environment plus a request-level
// reference model; honours RV32IMF_PREFETCH_BYPASS_EN like the design.
module tb_rv32imf_prefetch_controller;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk_i;
    logic             rst_ni;
    logic             req_i;
    logic             branch_i;
    logic [31:0]      branch_addr_i;
    logic             busy_o;
    logic             trans_valid_o;
    logic             trans_ready_i;
    logic [31:0]      trans_addr_o;
    logic             resp_valid_i;
    logic [31:0]      resp_rdata_i;
    logic             fetch_valid_o;
    logic             fetch_ready_i;
    logic [31:0]      fetch_rdata_o;
    logic             fifo_flush_o;
    logic             fifo_push_o;
    logic             fifo_pop_o;
    logic [CNT_W-1:0] fifo_cnt_i;
    logic             fifo_empty_i;
    logic [31:0]      fifo_rdata_i;

    rv32imf_prefetch_controller #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .busy_o        (busy_o),
        .trans_valid_o (trans_valid_o),
        .trans_ready_i (trans_ready_i),
        .trans_addr_o  (trans_addr_o),
        .resp_valid_i  (resp_valid_i),
        .resp_rdata_i  (resp_rdata_i),
        .fetch_valid_o (fetch_valid_o),
        .fetch_ready_i (fetch_ready_i),
        .fetch_rdata_o (fetch_rdata_o),
        .fifo_flush_o  (fifo_flush_o),
        .fifo_push_o   (fifo_push_o),
        .fifo_pop_o    (fifo_pop_o),
        .fifo_cnt_i    (fifo_cnt_i),
        .fifo_empty_i  (fifo_empty_i),
        .fifo_rdata_i  (fifo_rdata_i)
    );

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } req_t;

    int n_cmp = 0;
    int n_bad = 0;
    int acc_cnt = 0;

    // Environment: memory request queue and non-fall-through FIFO contents.
    logic [31:0] mq[$];
    logic [31:0] fq[$];
    bit          resp_en;

    // Reference model: outstanding requests tagged stale/fresh, words owed to the aligner.
    req_t        out_q[$];
    logic [31:0] exp_words[$];
    logic [31:0] next_pc;
    bit          redir;
    logic [31:0] redir_addr;

    logic        s_resp, s_acc, s_push, s_pop, s_flush;
    logic [31:0] s_addr, s_data;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a + 32'h1357_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_env();
        fifo_cnt_i   = CNT_W'(fq.size());
        fifo_empty_i = (fq.size() == 0);
        fifo_rdata_i = (fq.size() != 0) ? fq[0] : 32'h0;
        resp_valid_i = resp_en && (mq.size() != 0);
        resp_rdata_i = resp_valid_i ? mdata(mq[0]) : 32'h0;
    endtask

    task automatic set_resp(input bit en);
        resp_en = en;
        drive_env();
    endtask

    task automatic model_cmp();
        bit          exp_tv, exp_drop, exp_byp, exp_push, exp_pop, exp_fv, kept;
        logic [31:0] exp_ta, exp_rd;
        req_t        h;
        req_t        n;
        if (branch_i) begin
            exp_tv = 1'b1;
            exp_ta = {branch_addr_i[31:2], 2'b00};
        end else if (redir) begin
            exp_tv = 1'b1;
            exp_ta = redir_addr;
        end else begin
            exp_tv = req_i && (exp_words.size() + out_q.size() < DEPTH);
            exp_ta = next_pc;
        end
        exp_drop = branch_i || ((out_q.size() != 0) && out_q[0].stale);
`ifdef RV32IMF_PREFETCH_BYPASS_EN
        exp_byp = resp_valid_i && !exp_drop && (exp_words.size() == 0) && fetch_ready_i;
`else
        exp_byp = 1'b0;
`endif
        exp_push = resp_valid_i && !exp_drop && !exp_byp;
        exp_pop  = fetch_ready_i && (exp_words.size() != 0) && !branch_i;
        exp_fv   = ((exp_words.size() != 0) || exp_byp) && !branch_i;

        chk("trans_valid", 32'(trans_valid_o), 32'(exp_tv));
        if (exp_tv) chk("trans_addr", trans_addr_o, exp_ta);
        chk("busy", 32'(busy_o), 32'((out_q.size() != 0) || exp_tv));
        chk("fifo_flush", 32'(fifo_flush_o), 32'(branch_i));
        chk("fifo_push", 32'(fifo_push_o), 32'(exp_push));
        chk("fifo_pop", 32'(fifo_pop_o), 32'(exp_pop));
        chk("fetch_valid", 32'(fetch_valid_o), 32'(exp_fv));
        if (exp_fv && fetch_valid_o) begin
            exp_rd = (exp_words.size() != 0) ? exp_words[0] : mdata(out_q[0].addr);
            chk("fetch_rdata", fetch_rdata_o, exp_rd);
        end

        if (trans_valid_o && trans_ready_i) acc_cnt++;
        kept = 1'b0;
        h.addr = 32'h0;
        h.stale = 1'b0;
        if (resp_valid_i && (out_q.size() != 0)) begin
            h = out_q.pop_front();
            kept = !h.stale && !branch_i;
        end
        if (branch_i) begin
            foreach (out_q[i]) out_q[i].stale = 1'b1;
            exp_words.delete();
        end else begin
            if (exp_pop) void'(exp_words.pop_front());
            if (kept && !exp_byp) exp_words.push_back(mdata(h.addr));
        end
        if (exp_tv && trans_ready_i) begin
            n.addr = exp_ta;
            n.stale = 1'b0;
            out_q.push_back(n);
            next_pc = exp_ta + 32'd4;
            redir = 1'b0;
        end else if (branch_i) begin
            redir = 1'b1;
            redir_addr = {branch_addr_i[31:2], 2'b00};
        end

        s_resp  = resp_valid_i;
        s_acc   = trans_valid_o && trans_ready_i;
        s_addr  = trans_addr_o;
        s_push  = fifo_push_o;
        s_pop   = fifo_pop_o;
        s_flush = fifo_flush_o;
        s_data  = resp_rdata_i;
    endtask

    task automatic commit();
        if (s_resp && (mq.size() != 0)) void'(mq.pop_front());
        if (s_acc) mq.push_back(s_addr);
        if (s_flush) begin
            fq.delete();
        end else begin
            if (s_pop && (fq.size() != 0)) void'(fq.pop_front());
            if (s_push) fq.push_back(s_data);
        end
        chk("fifo_bound", 32'(fq.size() <= DEPTH), 32'd1);
        drive_env();
    endtask

    task automatic half();
        @(negedge clk_i);
        model_cmp();
    endtask

    task automatic fin();
        @(posedge clk_i);
        #1;
        commit();
    endtask

    task automatic cyc();
        half();
        fin();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        req_i = 1'b0;
        branch_i = 1'b0;
        branch_addr_i = 32'h0;
        trans_ready_i = 1'b0;
        fetch_ready_i = 1'b0;
        resp_en = 1'b1;
        out_q.delete();
        exp_words.delete();
        fq.delete();
        mq.delete();
        next_pc = 32'h0;
        redir = 1'b0;
        redir_addr = 32'h0;
        drive_env();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_trans_valid", 32'(trans_valid_o), 32'd0);
        chk("rst_trans_addr", trans_addr_o, 32'h0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_flush", 32'(fifo_flush_o), 32'd0);
        chk("rst_push", 32'(fifo_push_o), 32'd0);
        chk("rst_pop", 32'(fifo_pop_o), 32'd0);
        chk("rst_fetch_valid", 32'(fetch_valid_o), 32'd0);
        fifo_empty_i = 1'b0;
        #1;
        chk("rst_fetch_valid_nonempty", 32'(fetch_valid_o), 32'd1);
        fifo_empty_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Sequential streaming
        do_reset();
        req_i = 1'b1;
        trans_ready_i = 1'b1;
        fetch_ready_i = 1'b1;
        half();
        chk("t1_valid0", 32'(trans_valid_o), 32'd1);
        chk("t1_addr0", trans_addr_o, 32'h0);
        fin();
        half();
        chk("t1_addr1", trans_addr_o, 32'h4);
`ifdef RV32IMF_PREFETCH_BYPASS_EN
        chk("t1_byp_valid", 32'(fetch_valid_o), 32'd1);
        chk("t1_byp_rdata", fetch_rdata_o, 32'h1357_0000);
        chk("t1_byp_nopush", 32'(fifo_push_o), 32'd0);
`else
        chk("t1_push", 32'(fifo_push_o), 32'd1);
        chk("t1_not_yet", 32'(fetch_valid_o), 32'd0);
`endif
        fin();
        half();
        chk("t1_addr2", trans_addr_o, 32'h8);
`ifndef RV32IMF_PREFETCH_BYPASS_EN
        chk("t1_fifo_valid", 32'(fetch_valid_o), 32'd1);
        chk("t1_fifo_rdata", fetch_rdata_o, 32'h1357_0000);
`endif
        fin();
        repeat (8) cyc();

        // Credit limit with a stalled consumer
        do_reset();
        acc_cnt = 0;
        req_i = 1'b1;
        trans_ready_i = 1'b1;
        fetch_ready_i = 1'b0;
        repeat (10) cyc();
        half();
        chk("t2_accepts", 32'(acc_cnt), 32'd4);
        chk("t2_stalled", 32'(trans_valid_o), 32'd0);
        fin();
        fetch_ready_i = 1'b1;
        cyc();
        fetch_ready_i = 1'b0;
        repeat (6) cyc();
        half();
        chk("t2_one_more", 32'(acc_cnt), 32'd5);
        fin();

        // Redirect with two requests outstanding
        do_reset();
        set_resp(1'b0);
        req_i = 1'b1;
        trans_ready_i = 1'b1;
        fetch_ready_i = 1'b1;
        repeat (2) cyc();
        branch_i = 1'b1;
        branch_addr_i = 32'h0000_1002;
        half();
        chk("t3_flush", 32'(fifo_flush_o), 32'd1);
        chk("t3_valid", 32'(trans_valid_o), 32'd1);
        chk("t3_target", trans_addr_o, 32'h0000_1000);
        fin();
        branch_i = 1'b0;
        set_resp(1'b1);
        half();
        chk("t3_drop0", 32'(fifo_push_o), 32'd0);
        chk("t3_next_addr", trans_addr_o, 32'h0000_1004);
        fin();
        half();
        chk("t3_drop1", 32'(fifo_push_o), 32'd0);
        fin();
        half();
`ifdef RV32IMF_PREFETCH_BYPASS_EN
        chk("t3_first_byp_valid", 32'(fetch_valid_o), 32'd1);
        chk("t3_first_byp_rdata", fetch_rdata_o, 32'h1357_1000);
        chk("t3_first_byp_nopush", 32'(fifo_push_o), 32'd0);
        fin();
`else
        chk("t3_first_push", 32'(fifo_push_o), 32'd1);
        chk("t3_first_data", resp_rdata_i, 32'h1357_1000);
        fin();
        half();
        chk("t3_first_valid", 32'(fetch_valid_o), 32'd1);
        chk("t3_first_rdata", fetch_rdata_o, 32'h1357_1000);
        fin();
`endif
        repeat (6) cyc();

        // Redirect held off by trans_ready_i
        do_reset();
        req_i = 1'b1;
        trans_ready_i = 1'b1;
        fetch_ready_i = 1'b1;
        repeat (3) cyc();
        trans_ready_i = 1'b0;
        branch_i = 1'b1;
        branch_addr_i = 32'h0000_2000;
        half();
        chk("t4_valid_b", 32'(trans_valid_o), 32'd1);
        chk("t4_addr_b", trans_addr_o, 32'h0000_2000);
        fin();
        branch_i = 1'b0;
        for (int w = 0; w < 2; w++) begin
            half();
            chk("t4_wait_valid", 32'(trans_valid_o), 32'd1);
            chk("t4_wait_addr", trans_addr_o, 32'h0000_2000);
            fin();
        end
        trans_ready_i = 1'b1;
        half();
        chk("t4_acc_valid", 32'(trans_valid_o), 32'd1);
        chk("t4_acc_addr", trans_addr_o, 32'h0000_2000);
        fin();
        half();
        chk("t4_seq_addr", trans_addr_o, 32'h0000_2004);
        fin();

        // New redirect replaces a pending one
        trans_ready_i = 1'b0;
        branch_i = 1'b1;
        branch_addr_i = 32'h0000_4000;
        cyc();
        branch_addr_i = 32'h0000_5009;
        half();
        chk("t4b_replace", trans_addr_o, 32'h0000_5008);
        fin();
        branch_i = 1'b0;
        half();
        chk("t4b_hold_valid", 32'(trans_valid_o), 32'd1);
        chk("t4b_hold_addr", trans_addr_o, 32'h0000_5008);
        fin();
        trans_ready_i = 1'b1;
        repeat (6) cyc();

        // Mixed directed vector table
        for (int i = 0; i < 40; i++) begin
            req_i         = ((i % 7) != 3);
            trans_ready_i = ((i % 3) != 1);
            fetch_ready_i = ((i % 5) < 3);
            branch_i      = (i == 11) || (i == 23) || (i == 24);
            branch_addr_i = 32'(i) * 32'h100 + 32'd2;
            set_resp((i % 4) != 2);
            cyc();
        end

        // Drain
        branch_i = 1'b0;
        req_i = 1'b0;
        trans_ready_i = 1'b1;
        fetch_ready_i = 1'b1;
        set_resp(1'b1);
        repeat (12) cyc();
        half();
        chk("drain_idle", 32'(busy_o), 32'd0);
        chk("drain_empty", 32'(fetch_valid_o), 32'd0);
        fin();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rv32imf_prefetch_controller.md
# rv32imf_prefetch_controller

Instruction-fetch request controller sitting directly upstream of the prefetch FIFO (`rv32imf_fifo`, non-fall-through, depth `DEPTH`). It issues word-aligned OBI-style fetch transactions and tracks outstanding responses so the FIFO can never overflow. It pushes returned instruction words into the FIFO, discards stale responses after a branch, and presents a valid/ready fetch stream to the aligner downstream.

## Interface
- `DEPTH`, 4: prefetch FIFO depth; must match the attached FIFO; ≥2.
- `CNT_W`, `$clog2(DEPTH)+1`: width of the FIFO count and the outstanding counters (derived).

- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_i` in 1: fetch enable.
- `branch_i` in 1: redirect pulse, one cycle.
- `branch_addr_i` in 32: redirect target.
- `busy_o` out 1: transaction pending or being requested.
- `trans_valid_o` out 1: request valid.
- `trans_ready_i` in 1: request accepted.
- `trans_addr_o` out 32: word-aligned request address.
- `resp_valid_i` in 1: response beat.
- `resp_rdata_i` in 32: response data.
- `fetch_valid_o` out 1: instruction word available downstream.
- `fetch_ready_i` in 1: downstream consumes the word.
- `fetch_rdata_o` out 32: instruction word.
- `fifo_flush_o` out 1: FIFO flush.
- `fifo_push_o` out 1: FIFO push; FIFO `data_i` = `resp_rdata_i`.
- `fifo_pop_o` out 1: FIFO pop.
- `fifo_cnt_i` in CNT_W: FIFO occupancy.
- `fifo_empty_i` in 1: FIFO empty.
- `fifo_rdata_i` in 32: FIFO head data.

## Operation
- States:
  - IDLE: normal sequential fetch.
  - BRANCH_WAIT: redirect request not yet accepted.
- Registers: `state_q`, `addr_q[31:0]` (last accepted address), `cnt_q` (outstanding), `flush_cnt_q` (responses to drop).
- IDLE request:
  - `trans_valid_o = req_i && (fifo_cnt_i + cnt_q < DEPTH)`.
  - `trans_addr_o = {addr_q[31:2],2'b00} + 4`.
- Branch, any state:
  - `trans_valid_o = 1` and `trans_addr_o = {branch_addr_i[31:2],2'b00}`, regardless of `req_i` or credit.
  - If `trans_ready_i` = 0: `addr_q <= branch_addr_i - 4` (aligned); go to BRANCH_WAIT.
- BRANCH_WAIT:
  - `trans_valid_o = 1`; `trans_addr_o = addr_q + 4`.
  - Return to IDLE on `trans_ready_i`.
  - A new `branch_i` replaces the target.
- On accept (`trans_valid_o && trans_ready_i`): `addr_q <= trans_addr_o`.
- `cnt_q`:
  - +1 on accept; −1 on `resp_valid_i`; unchanged when both occur.
  - `resp_valid_i` with `cnt_q==0` is a protocol violation: ignored, no underflow.
- `flush_cnt_q`:
  - On `branch_i`: `flush_cnt_q <= cnt_q - resp_valid_i`.
  - Otherwise decrements on `resp_valid_i` while nonzero.
  - A response is dropped when `flush_cnt_q != 0` or `branch_i`.
- `fifo_flush_o = branch_i`.
- `fifo_push_o = resp_valid_i && !drop && !bypass`.
- `fifo_pop_o = fetch_ready_i && !fifo_empty_i && !branch_i`.
- Fetch output:
  - `fetch_valid_o = (!fifo_empty_i || bypass) && !branch_i`.
  - `fetch_rdata_o = bypass ? resp_rdata_i : fifo_rdata_i`.
- `busy_o = (cnt_q != 0) || trans_valid_o`.

## Timing
- Reset values: state IDLE, `addr_q = 32'hFFFF_FFFC` (first sequential fetch is 0x0), `cnt_q = 0`, `flush_cnt_q = 0`.
- Outputs in reset with `req_i`=`branch_i`=0: all 0. Exception: `fetch_valid_o = !fifo_empty_i`.
- Request outputs are combinational from state and inputs. One accept per cycle maximum.
- Response-to-`fetch_valid_o` latency:
  - 1 cycle through the FIFO.
  - 0 cycles in bypass.
- Branch:
  - Flush and redirect request happen in the same cycle as `branch_i`.
  - The first post-branch word is pushed only after all pre-branch responses are dropped.
- Credit rule: `fifo_cnt_i + cnt_q ≤ DEPTH` at all times.

## Configuration
- `RV32IMF_PREFETCH_BYPASS_EN` defined:
  - `bypass = resp_valid_i && !drop && fifo_empty_i && fetch_ready_i`.
  - Response forwarded combinationally to `fetch_rdata_o` with no push.
- Undefined: `bypass = 0`; every kept response goes through the FIFO.

## Test plan
- Reset, `req_i`=1, `trans_ready_i`=1, responses 1 cycle later: addresses 0x0, 0x4, 0x8…; words appear on `fetch_valid_o` in order with 1-cycle latency.
- `fetch_ready_i`=0 throughout, DEPTH=4: exactly 4 accepts, then `trans_valid_o`=0 until one pop, after which exactly one new request issues.
- Two requests outstanding, `branch_i` to 0x1002: `fifo_flush_o`=1, `trans_addr_o`=0x1000; both old responses dropped (no push); first pushed word is from 0x1000, next request is 0x1004.
- Branch with `trans_ready_i`=0 for 3 cycles: BRANCH_WAIT holds `trans_addr_o`=target, `trans_valid_o`=1; accept on cycle 4, then back to IDLE.
- `resp_valid_i` in the same cycle as accept: `cnt_q` unchanged.
- With `RV32IMF_PREFETCH_BYPASS_EN`: FIFO empty and `fetch_ready_i`=1 gives the response on `fetch_rdata_o` in the same cycle with `fifo_push_o`=0. Without the macro, the same stimulus gives `fifo_push_o`=1 and `fetch_valid_o` one cycle later.
